// File: rtl/can_rx_frame_engine.sv
`default_nettype none
//==============================================================================
// Module   : can_rx_frame_engine
// Desc     : CAN 2.0A/B receive engine. Consumes one bus bit per sample_point,
//            removes stuff bits, checks CRC-15 and frame form, drives the ACK
//            slot, filters on ID and hands accepted frames to a single-entry
//            valid/ready holding register with overrun detection.
// Revision : 1.0 - initial release
//==============================================================================
module can_rx_frame_engine #(
    parameter int MAX_DATA_BYTES = 8,
    parameter int NUM_FILTERS    = 2,
    parameter int STUFF_LIMIT    = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_bit,
    input  logic                        sample_point,
    input  logic [NUM_FILTERS-1:0]      filt_en,
    input  logic [NUM_FILTERS*30-1:0]   filt_id,
    input  logic [NUM_FILTERS*30-1:0]   filt_mask,
    input  logic                        frame_ready,
    output logic                        frame_valid,
    output logic [28:0]                 frame_id,
    output logic                        frame_ide,
    output logic                        frame_rtr,
    output logic [3:0]                  frame_dlc,
    output logic [8*MAX_DATA_BYTES-1:0] frame_data,
    output logic [2:0]                  frame_hit_idx,
    output logic                        ack_drive,
    output logic                        err_stuff,
    output logic                        err_crc,
    output logic                        err_form,
    output logic                        overrun,
    output logic                        rx_busy
);

    localparam int c_DATA_W = 8 * MAX_DATA_BYTES;
    localparam int c_RUN_W  = $clog2(STUFF_LIMIT + 1);
    localparam logic [c_RUN_W-1:0] c_RUN_MAX = c_RUN_W'(STUFF_LIMIT);
    localparam logic [c_RUN_W-1:0] c_RUN_ONE = c_RUN_W'(1);
    localparam logic [14:0] c_CRC_POLY = 15'h4599;

    // Protocol states; codes ID_STD..DATA form a contiguous CRC-covered range
    localparam logic [3:0] c_ST_INTEGRATE = 4'd0;
    localparam logic [3:0] c_ST_IDLE      = 4'd1;
    localparam logic [3:0] c_ST_ID_STD    = 4'd2;
    localparam logic [3:0] c_ST_SRR_RTR   = 4'd3;
    localparam logic [3:0] c_ST_IDE       = 4'd4;
    localparam logic [3:0] c_ST_ID_EXT    = 4'd5;
    localparam logic [3:0] c_ST_RTR       = 4'd6;
    localparam logic [3:0] c_ST_R1        = 4'd7;
    localparam logic [3:0] c_ST_R0        = 4'd8;
    localparam logic [3:0] c_ST_DLC       = 4'd9;
    localparam logic [3:0] c_ST_DATA      = 4'd10;
    localparam logic [3:0] c_ST_CRC       = 4'd11;
    localparam logic [3:0] c_ST_CRC_DELIM = 4'd12;
    localparam logic [3:0] c_ST_ACK       = 4'd13;
    localparam logic [3:0] c_ST_ACK_DELIM = 4'd14;
    localparam logic [3:0] c_ST_EOF       = 4'd15;

    logic [3:0]          r_state;
    logic [6:0]          r_cnt;
    logic [14:0]         r_crc;
    logic [14:0]         r_crc_rx;
    logic [c_RUN_W-1:0]  r_run_cnt;
    logic                r_last_bit;
    logic [10:0]         r_base;
    logic [17:0]         r_ext;
    logic                r_srr;
    logic                r_ide;
    logic                r_rtr;
    logic [3:0]          r_dlc;
    logic [c_DATA_W-1:0] r_data;
    logic                r_ack;
    logic                r_err_stuff;
    logic                r_err_crc;
    logic                r_err_form;
    logic                r_busy;

    logic                r_frame_valid;
    logic [28:0]         r_frame_id;
    logic                r_frame_ide;
    logic                r_frame_rtr;
    logic [3:0]          r_frame_dlc;
    logic [c_DATA_W-1:0] r_frame_data;
    logic [2:0]          r_frame_hit;
    logic                r_overrun;

    logic                w_stuff_zone;
    logic                w_is_stuff;
    logic                w_crc_fb;
    logic [14:0]         w_crc_nxt;
    logic [3:0]          w_dlc_nxt;
    logic [6:0]          w_data_bits;
    logic [c_DATA_W-1:0] w_data_nxt;
    logic [29:0]         w_cand;
    logic                w_hit_any;
    logic [2:0]          w_hit_idx;
    logic                w_accept;
    logic                w_load;

    // Stuff bits are expected in the arbitration..CRC fields, and once more
    // right after the last CRC bit if that bit completed a run
    assign w_stuff_zone = ((r_state >= c_ST_ID_STD) && (r_state <= c_ST_CRC)) ||
                          ((r_state == c_ST_CRC_DELIM) && (r_run_cnt == c_RUN_MAX));
    assign w_is_stuff   = w_stuff_zone && (r_run_cnt == c_RUN_MAX);

    assign w_crc_fb    = rx_bit ^ r_crc[14];
    assign w_crc_nxt   = {r_crc[13:0], 1'b0} ^ (w_crc_fb ? c_CRC_POLY : 15'h0000);
    assign w_dlc_nxt   = {r_dlc[2:0], rx_bit};
    assign w_data_bits = (r_dlc > 4'd8) ? 7'd64 : {r_dlc, 3'b000};

    // Place the incoming data bit; bytes beyond the storage depth are dropped
    always_comb begin
        w_data_nxt = r_data;
        for (int b = 0; b < MAX_DATA_BYTES; b++) begin
            for (int k = 0; k < 8; k++) begin
                if ((r_cnt[5:3] == 3'(b)) && (r_cnt[2:0] == 3'(7 - k))) begin
                    w_data_nxt[8*b + k] = rx_bit;
                end
            end
        end
    end

    // Acceptance filtering: lowest enabled matching filter wins
    always_comb begin
        w_cand    = {r_ide, r_base, r_ext};
        w_hit_any = 1'b0;
        w_hit_idx = 3'd0;
        for (int k = NUM_FILTERS - 1; k >= 0; k--) begin
            if (filt_en[k] &&
                (((w_cand ^ filt_id[30*k +: 30]) & filt_mask[30*k +: 30]) == 30'd0)) begin
                w_hit_any = 1'b1;
                w_hit_idx = 3'(k);
            end
        end
    end

    assign w_accept = (filt_en == '0) || w_hit_any;
    assign w_load   = sample_point && (r_state == c_ST_EOF) && (r_cnt == 7'd5) &&
                      rx_bit && w_accept;

    // Bit-level receive state machine, advancing only on sample_point
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_INTEGRATE;
            r_cnt       <= 7'd0;
            r_crc       <= 15'd0;
            r_crc_rx    <= 15'd0;
            r_run_cnt   <= '0;
            r_last_bit  <= 1'b0;
            r_base      <= 11'd0;
            r_ext       <= 18'd0;
            r_srr       <= 1'b0;
            r_ide       <= 1'b0;
            r_rtr       <= 1'b0;
            r_dlc       <= 4'd0;
            r_data      <= '0;
            r_ack       <= 1'b0;
            r_err_stuff <= 1'b0;
            r_err_crc   <= 1'b0;
            r_err_form  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_err_stuff <= 1'b0;
            r_err_crc   <= 1'b0;
            r_err_form  <= 1'b0;
            if (sample_point) begin
                if (w_is_stuff) begin
                    if (rx_bit == r_last_bit) begin
                        r_err_stuff <= 1'b1;
                        r_state     <= c_ST_INTEGRATE;
                        r_cnt       <= 7'd0;
                        r_ack       <= 1'b0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_run_cnt  <= c_RUN_ONE;
                        r_last_bit <= rx_bit;
                    end
                end else begin
                    if (w_stuff_zone) begin
                        if (rx_bit == r_last_bit) begin
                            r_run_cnt <= r_run_cnt + c_RUN_ONE;
                        end else begin
                            r_run_cnt  <= c_RUN_ONE;
                            r_last_bit <= rx_bit;
                        end
                    end
                    if ((r_state >= c_ST_ID_STD) && (r_state <= c_ST_DATA)) begin
                        r_crc <= w_crc_nxt;
                    end
                    case (r_state)
                        c_ST_INTEGRATE: begin
                            if (!rx_bit) begin
                                r_cnt <= 7'd0;
                            end else if (r_cnt == 7'd10) begin
                                r_cnt   <= 7'd0;
                                r_state <= c_ST_IDLE;
                            end else begin
                                r_cnt <= r_cnt + 7'd1;
                            end
                        end
                        c_ST_IDLE: begin
                            if (!rx_bit) begin
                                // SOF: a dominant bit into a zero CRC leaves it zero
                                r_state    <= c_ST_ID_STD;
                                r_cnt      <= 7'd0;
                                r_crc      <= 15'd0;
                                r_crc_rx   <= 15'd0;
                                r_run_cnt  <= c_RUN_ONE;
                                r_last_bit <= 1'b0;
                                r_base     <= 11'd0;
                                r_ext      <= 18'd0;
                                r_srr      <= 1'b0;
                                r_ide      <= 1'b0;
                                r_rtr      <= 1'b0;
                                r_dlc      <= 4'd0;
                                r_data     <= '0;
                                r_busy     <= 1'b1;
                            end
                        end
                        c_ST_ID_STD: begin
                            r_base <= {r_base[9:0], rx_bit};
                            if (r_cnt == 7'd10) begin
                                r_cnt   <= 7'd0;
                                r_state <= c_ST_SRR_RTR;
                            end else begin
                                r_cnt <= r_cnt + 7'd1;
                            end
                        end
                        c_ST_SRR_RTR: begin
                            r_srr   <= rx_bit;
                            r_state <= c_ST_IDE;
                        end
                        c_ST_IDE: begin
                            r_ide <= rx_bit;
                            if (rx_bit) begin
                                r_state <= c_ST_ID_EXT;
                            end else begin
                                r_rtr   <= r_srr;
                                r_state <= c_ST_R0;
                            end
                        end
                        c_ST_ID_EXT: begin
                            r_ext <= {r_ext[16:0], rx_bit};
                            if (r_cnt == 7'd17) begin
                                r_cnt   <= 7'd0;
                                r_state <= c_ST_RTR;
                            end else begin
                                r_cnt <= r_cnt + 7'd1;
                            end
                        end
                        c_ST_RTR: begin
                            r_rtr   <= rx_bit;
                            r_state <= c_ST_R1;
                        end
                        c_ST_R1: begin
                            r_state <= c_ST_R0;
                        end
                        c_ST_R0: begin
                            r_cnt   <= 7'd0;
                            r_state <= c_ST_DLC;
                        end
                        c_ST_DLC: begin
                            r_dlc <= w_dlc_nxt;
                            if (r_cnt == 7'd3) begin
                                r_cnt <= 7'd0;
                                if (r_rtr || (w_dlc_nxt == 4'd0)) begin
                                    r_state <= c_ST_CRC;
                                end else begin
                                    r_state <= c_ST_DATA;
                                end
                            end else begin
                                r_cnt <= r_cnt + 7'd1;
                            end
                        end
                        c_ST_DATA: begin
                            r_data <= w_data_nxt;
                            if (r_cnt == (w_data_bits - 7'd1)) begin
                                r_cnt   <= 7'd0;
                                r_state <= c_ST_CRC;
                            end else begin
                                r_cnt <= r_cnt + 7'd1;
                            end
                        end
                        c_ST_CRC: begin
                            r_crc_rx <= {r_crc_rx[13:0], rx_bit};
                            if (r_cnt == 7'd14) begin
                                r_cnt   <= 7'd0;
                                r_state <= c_ST_CRC_DELIM;
                            end else begin
                                r_cnt <= r_cnt + 7'd1;
                            end
                        end
                        c_ST_CRC_DELIM: begin
                            if ((r_crc_rx != r_crc) || !rx_bit) begin
                                r_err_crc  <= (r_crc_rx != r_crc);
                                r_err_form <= !rx_bit;
                                r_state    <= c_ST_INTEGRATE;
                                r_cnt      <= 7'd0;
                                r_ack      <= 1'b0;
                                r_busy     <= 1'b0;
                            end else begin
                                r_ack   <= 1'b1;
                                r_state <= c_ST_ACK;
                            end
                        end
                        c_ST_ACK: begin
                            r_ack   <= 1'b0;
                            r_state <= c_ST_ACK_DELIM;
                        end
                        c_ST_ACK_DELIM: begin
                            if (!rx_bit) begin
                                r_err_form <= 1'b1;
                                r_state    <= c_ST_INTEGRATE;
                                r_busy     <= 1'b0;
                            end else begin
                                r_state <= c_ST_EOF;
                            end
                            r_cnt <= 7'd0;
                        end
                        c_ST_EOF: begin
                            // The last EOF bit is tolerated dominant
                            if (r_cnt == 7'd6) begin
                                r_cnt   <= 7'd0;
                                r_state <= c_ST_IDLE;
                                r_busy  <= 1'b0;
                            end else if (!rx_bit) begin
                                r_err_form <= 1'b1;
                                r_cnt      <= 7'd0;
                                r_state    <= c_ST_INTEGRATE;
                                r_busy     <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + 7'd1;
                            end
                        end
                        default: begin
                            r_state <= c_ST_INTEGRATE;
                            r_cnt   <= 7'd0;
                        end
                    endcase
                end
            end
        end
    end

    // Single-entry holding register: load on completion, clear on consume,
    // keep the old frame and flag overrun if it has not been taken yet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_valid <= 1'b0;
            r_frame_id    <= 29'd0;
            r_frame_ide   <= 1'b0;
            r_frame_rtr   <= 1'b0;
            r_frame_dlc   <= 4'd0;
            r_frame_data  <= '0;
            r_frame_hit   <= 3'd0;
            r_overrun     <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_load) begin
                if (r_frame_valid && !frame_ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_frame_valid <= 1'b1;
                    r_frame_id    <= {r_base, r_ext};
                    r_frame_ide   <= r_ide;
                    r_frame_rtr   <= r_rtr;
                    r_frame_dlc   <= r_dlc;
                    r_frame_data  <= r_data;
                    r_frame_hit   <= w_hit_idx;
                end
            end else if (r_frame_valid && frame_ready) begin
                r_frame_valid <= 1'b0;
            end
        end
    end

    assign frame_valid   = r_frame_valid;
    assign frame_id      = r_frame_id;
    assign frame_ide     = r_frame_ide;
    assign frame_rtr     = r_frame_rtr;
    assign frame_dlc     = r_frame_dlc;
    assign frame_data    = r_frame_data;
    assign frame_hit_idx = r_frame_hit;
    assign ack_drive     = r_ack;
    assign err_stuff     = r_err_stuff;
    assign err_crc       = r_err_crc;
    assign err_form      = r_err_form;
    assign overrun       = r_overrun;
    assign rx_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_can_rx_frame_engine.sv
`default_nettype none
//==============================================================================
// Module   : tb_can_rx_frame_engine
// Desc     : Directed bench for can_rx_frame_engine. Builds stuffed CAN frames
//            with an independent CRC-15 model and scoreboards delivered frames.
// Revision : 1.0 - initial release
//==============================================================================
module tb_can_rx_frame_engine;

    localparam int c_MAXB = 4;
    localparam int c_NF   = 2;
    localparam int c_BT   = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  rx_bit;
    logic                  sample_point;
    logic [c_NF-1:0]       filt_en;
    logic [c_NF*30-1:0]    filt_id;
    logic [c_NF*30-1:0]    filt_mask;
    logic                  frame_ready;
    logic                  frame_valid;
    logic [28:0]           frame_id;
    logic                  frame_ide;
    logic                  frame_rtr;
    logic [3:0]            frame_dlc;
    logic [8*c_MAXB-1:0]   frame_data;
    logic [2:0]            frame_hit_idx;
    logic                  ack_drive;
    logic                  err_stuff;
    logic                  err_crc;
    logic                  err_form;
    logic                  overrun;
    logic                  rx_busy;

    typedef struct {
        logic [28:0] id;
        logic        ide;
        logic        rtr;
        logic [3:0]  dlc;
        logic [31:0] data;
        logic [2:0]  hit;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t drv_e;
    bit   fb[$];

    int tests = 0;
    int fails = 0;
    int n_stuff, n_crc, n_form, n_ovr, n_ack, n_busy, n_unexp;

    logic [28:0] xid;

    can_rx_frame_engine #(
        .MAX_DATA_BYTES (c_MAXB),
        .NUM_FILTERS    (c_NF),
        .STUFF_LIMIT    (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_bit        (rx_bit),
        .sample_point  (sample_point),
        .filt_en       (filt_en),
        .filt_id       (filt_id),
        .filt_mask     (filt_mask),
        .frame_ready   (frame_ready),
        .frame_valid   (frame_valid),
        .frame_id      (frame_id),
        .frame_ide     (frame_ide),
        .frame_rtr     (frame_rtr),
        .frame_dlc     (frame_dlc),
        .frame_data    (frame_data),
        .frame_hit_idx (frame_hit_idx),
        .ack_drive     (ack_drive),
        .err_stuff     (err_stuff),
        .err_crc       (err_crc),
        .err_form      (err_form),
        .overrun       (overrun),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_cnt();
        n_stuff = 0; n_crc = 0; n_form = 0; n_ovr = 0; n_ack = 0; n_busy = 0;
    endtask

    // Pulse counters and scoreboard pop, sampled away from the active edge
    always @(negedge clk) begin
        if (err_stuff) n_stuff++;
        if (err_crc)   n_crc++;
        if (err_form)  n_form++;
        if (overrun)   n_ovr++;
        if (ack_drive) n_ack++;
        if (rx_busy)   n_busy++;
        if (frame_valid && frame_ready) begin
            if (sb.size() == 0) begin
                n_unexp++;
            end else begin
                mon_e = sb.pop_front();
                chk("frame_id",  64'(frame_id),      64'(mon_e.id));
                chk("frame_ide", 64'(frame_ide),     64'(mon_e.ide));
                chk("frame_rtr", 64'(frame_rtr),     64'(mon_e.rtr));
                chk("frame_dlc", 64'(frame_dlc),     64'(mon_e.dlc));
                chk("frame_data", 64'(frame_data),   64'(mon_e.data));
                chk("frame_hit", 64'(frame_hit_idx), 64'(mon_e.hit));
            end
        end
    end

    task automatic send_bit(input bit b);
        rx_bit = b;
        repeat (2) begin @(posedge clk); #1; end
        sample_point = 1'b1;
        @(posedge clk); #1;
        sample_point = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_fb();
        foreach (fb[i]) send_bit(fb[i]);
    endtask

    task automatic send_ones(input int n);
        repeat (n) send_bit(1'b1);
    endtask

    // Build a full frame bit stream (SOF..intermission) into fb
    task automatic build(input bit ide, input logic [10:0] base, input logic [17:0] ext,
                         input bit rtr, input logic [3:0] dlc, input logic [63:0] data,
                         input bit bad_crc, input bit ack_delim);
        bit          raw[$];
        logic [14:0] crc;
        int          nb;
        int          run;
        bit          last;
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(base[i]);
        if (!ide) begin
            raw.push_back(rtr); raw.push_back(1'b0); raw.push_back(1'b0);
        end else begin
            raw.push_back(1'b1); raw.push_back(1'b1);
            for (int i = 17; i >= 0; i--) raw.push_back(ext[i]);
            raw.push_back(rtr); raw.push_back(1'b0); raw.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int b = 0; b < nb; b++)
            for (int i = 7; i >= 0; i--) raw.push_back(data[8*b + i]);
        crc = 15'd0;
        foreach (raw[i]) begin
            bit fbk;
            fbk = raw[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (fbk) crc = crc ^ 15'h4599;
        end
        if (bad_crc) crc[0] = ~crc[0];
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        fb.delete();
        run  = 0;
        last = 1'b1;
        foreach (raw[i]) begin
            fb.push_back(raw[i]);
            if (raw[i] == last) run++;
            else begin run = 1; last = raw[i]; end
            if (run == 5) begin fb.push_back(~last); last = ~last; run = 1; end
        end
        fb.push_back(1'b1);
        fb.push_back(1'b0);
        fb.push_back(ack_delim);
        repeat (7) fb.push_back(1'b1);
        repeat (3) fb.push_back(1'b1);
    endtask

    task automatic expect_frame(input logic [28:0] id, input bit ide, input bit rtr,
                                input logic [3:0] dlc, input logic [31:0] data,
                                input logic [2:0] hit);
        drv_e.id = id; drv_e.ide = ide; drv_e.rtr = rtr;
        drv_e.dlc = dlc; drv_e.data = data; drv_e.hit = hit;
        sb.push_back(drv_e);
    endtask

    initial begin
        rst = 1'b1; rx_bit = 1'b1; sample_point = 1'b0;
        filt_en = '0; filt_id = '0; filt_mask = '0; frame_ready = 1'b1;
        n_unexp = 0;
        clr_cnt();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 64'({frame_valid, frame_ide, frame_rtr, frame_dlc, frame_hit_idx,
                               ack_drive, err_stuff, err_crc, err_form, overrun, rx_busy,
                               frame_id}), 64'd0);
        chk("reset_data", 64'(frame_data), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        send_ones(12);

        // Standard data frame 0x123, two bytes
        clr_cnt();
        expect_frame({11'h123, 18'd0}, 1'b0, 1'b0, 4'd2, 32'h0000_0FA5, 3'd0);
        build(1'b0, 11'h123, 18'd0, 1'b0, 4'd2, 64'h0FA5, 1'b0, 1'b1);
        send_fb();
        chk("std_ack_clks", 64'(n_ack), 64'(c_BT));
        chk("std_delivered", 64'(sb.size()), 64'd0);
        chk("std_no_err", 64'(n_stuff + n_crc + n_form), 64'd0);
        chk("std_busy_seen", 64'(n_busy > 0), 64'd1);

        // Extended remote frame, DLC 4, no data consumed
        clr_cnt();
        xid = 29'h1ABCDEF0;
        expect_frame(xid, 1'b1, 1'b1, 4'd4, 32'd0, 3'd0);
        build(1'b1, xid[28:18], xid[17:0], 1'b1, 4'd4, 64'hDEAD_BEEF, 1'b0, 1'b1);
        send_fb();
        chk("ext_rtr_ack_clks", 64'(n_ack), 64'(c_BT));
        chk("ext_rtr_delivered", 64'(sb.size()), 64'd0);

        // Stuff violation right after SOF, then recovery
        clr_cnt();
        fb.delete();
        repeat (6) fb.push_back(1'b0);
        repeat (14) fb.push_back(1'b1);
        send_fb();
        chk("stuff_err_pulse", 64'(n_stuff), 64'd1);
        chk("stuff_no_ack", 64'(n_ack), 64'd0);
        chk("stuff_busy_dropped", 64'(rx_busy), 64'd0);
        clr_cnt();
        expect_frame({11'h055, 18'd0}, 1'b0, 1'b0, 4'd1, 32'h0000_003C, 3'd0);
        build(1'b0, 11'h055, 18'd0, 1'b0, 4'd1, 64'h3C, 1'b0, 1'b1);
        send_fb();
        chk("recover_delivered", 64'(sb.size()), 64'd0);
        chk("recover_ack_clks", 64'(n_ack), 64'(c_BT));

        // Corrupted CRC
        clr_cnt();
        build(1'b0, 11'h2AA, 18'd0, 1'b0, 4'd1, 64'h77, 1'b1, 1'b1);
        send_fb();
        send_ones(12);
        chk("crc_err_pulse", 64'(n_crc), 64'd1);
        chk("crc_no_ack", 64'(n_ack), 64'd0);

        // ACK delimiter forced dominant
        clr_cnt();
        build(1'b0, 11'h2AA, 18'd0, 1'b0, 4'd1, 64'h77, 1'b0, 1'b0);
        send_fb();
        send_ones(12);
        chk("form_err_pulse", 64'(n_form), 64'd1);
        chk("form_ack_clks", 64'(n_ack), 64'(c_BT));
        chk("form_no_crc_err", 64'(n_crc), 64'd0);

        // Filter 1 matches standard ID 0x100 exactly
        filt_en   = 2'b10;
        filt_id   = {30'({1'b0, 11'h100, 18'd0}), 30'd0};
        filt_mask = {30'h3FFF_FFFF, 30'd0};
        clr_cnt();
        expect_frame({11'h100, 18'd0}, 1'b0, 1'b0, 4'd1, 32'h0000_0011, 3'd1);
        build(1'b0, 11'h100, 18'd0, 1'b0, 4'd1, 64'h11, 1'b0, 1'b1);
        send_fb();
        chk("filt_hit_delivered", 64'(sb.size()), 64'd0);
        clr_cnt();
        build(1'b0, 11'h101, 18'd0, 1'b0, 4'd1, 64'h22, 1'b0, 1'b1);
        send_fb();
        chk("filt_miss_acked", 64'(n_ack), 64'(c_BT));
        chk("filt_miss_no_ovr", 64'(n_ovr), 64'd0);
        filt_en = '0;

        // Overrun with consumer stalled; DLC 8 truncated to stored bytes
        frame_ready = 1'b0;
        clr_cnt();
        expect_frame({11'h321, 18'd0}, 1'b0, 1'b0, 4'd8, 32'h4433_2211, 3'd0);
        build(1'b0, 11'h321, 18'd0, 1'b0, 4'd8, 64'h8877_6655_4433_2211, 1'b0, 1'b1);
        send_fb();
        build(1'b0, 11'h322, 18'd0, 1'b0, 4'd1, 64'h99, 1'b0, 1'b1);
        send_fb();
        chk("ovr_pulse", 64'(n_ovr), 64'd1);
        chk("ovr_both_acked", 64'(n_ack), 64'(2 * c_BT));
        chk("ovr_no_crc_err", 64'(n_crc), 64'd0);
        chk("ovr_valid_held", 64'(frame_valid), 64'd1);
        chk("ovr_old_data", 64'(frame_data), 64'h4433_2211);
        chk("ovr_pending", 64'(sb.size()), 64'd1);
        frame_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        chk("ovr_drained", 64'(sb.size()), 64'd0);
        chk("ovr_valid_cleared", 64'(frame_valid), 64'd0);

        chk("no_unexpected_frames", 64'(n_unexp), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
